// File: rtl/robm_cmd_sched_if.sv
// robm command scheduler bus: requester side, robm x/y side, status.
// master drives requests and y; slave is the scheduler.
interface robm_cmd_sched_if #(
  parameter int XW = 12,
  parameter int YW = 10
);
  logic          req0;
  logic [XW-1:0] cmd0;
  logic          req1;
  logic [XW-1:0] cmd1;
  logic          gnt0;
  logic          gnt1;
  logic          owner;
  logic          busy;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_in;
  logic          done;
  logic          timeout;
  logic [YW-1:0] ymask;

  modport master (
    output req0, cmd0, req1, cmd1, y_in,
    input  gnt0, gnt1, owner, busy,
    input  x_out, done, timeout, ymask
  );

  modport slave (
    input  req0, cmd0, req1, cmd1, y_in,
    output gnt0, gnt1, owner, busy,
    output x_out, done, timeout, ymask
  );
endinterface

// File: rtl/robm_cmd_sched.sv
// Round-robin command scheduler driving robm x inputs and
// watching y5 for completion or timeout.
module robm_cmd_sched #(
  parameter int XW   = 12,
  parameter int YW   = 10,
  parameter int HOLD = 1,
  parameter int TMO  = 200
) (
  input logic               clk,
  input logic               rst,
  robm_cmd_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT
  } state_t;

  state_t        state;
  logic [XW-1:1] cmd_reg;
  logic [3:0]    hold_cnt;
  logic [7:0]    wait_cnt;
  logic          done_pend;
  logic          pick1;
  logic          y5;

  // tie goes to whoever did not own the last transaction
  assign pick1 = bus.req1 & (~bus.req0 | ~bus.owner);
  assign y5    = bus.y_in[4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cmd_reg     <= '0;
      hold_cnt    <= '0;
      wait_cnt    <= '0;
      done_pend   <= 1'b0;
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.owner   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.x_out   <= '0;
      bus.done    <= 1'b0;
      bus.timeout <= 1'b0;
      bus.ymask   <= '0;
    end else begin
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.done    <= 1'b0;
      bus.timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            state     <= DRIVE;
            bus.busy  <= 1'b1;
            hold_cnt  <= 4'(HOLD - 1);
            bus.ymask <= '0;
            done_pend <= 1'b0;
            if (pick1) begin
              bus.gnt1  <= 1'b1;
              bus.owner <= 1'b1;
              cmd_reg   <= bus.cmd1[XW-1:1];
              bus.x_out <= bus.cmd1;
            end else begin
              bus.gnt0  <= 1'b1;
              bus.owner <= 1'b0;
              cmd_reg   <= bus.cmd0[XW-1:1];
              bus.x_out <= bus.cmd0;
            end
          end
        end
        DRIVE: begin
          bus.ymask <= bus.ymask | bus.y_in;
          if (y5) done_pend <= 1'b1;
          if (hold_cnt == 4'd0) begin
            state     <= WAIT;
            wait_cnt  <= '0;
            // drop x1 so robm parks in s1 once it returns
            bus.x_out <= {cmd_reg, 1'b0};
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        WAIT: begin
          bus.ymask <= bus.ymask | bus.y_in;
          if (y5 | done_pend) begin
            state     <= IDLE;
            bus.done  <= 1'b1;
            bus.busy  <= 1'b0;
            bus.x_out <= '0;
          end else if (wait_cnt == 8'(TMO - 1)) begin
            state       <= IDLE;
            bus.timeout <= 1'b1;
            bus.busy    <= 1'b0;
            bus.x_out   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_robm_cmd_sched.sv
// Bench for robm_cmd_sched: directed scenarios plus random
// transactions checked against a per-transaction timing model.
module tb_robm_cmd_sched;
  localparam int XW = 12;
  localparam int YW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [XW-1:0] cmd0 = '0;
  logic [XW-1:0] cmd1 = '0;
  logic [YW-1:0] y_in = '0;

  int tests = 0;
  int fails = 0;
  int sel = 0;
  int H = 1;
  int T = 4;
  bit m_owner = 1'b0;
  logic [YW-1:0] m_mask = '0;

  always #5 clk = ~clk;

  robm_cmd_sched_if #(.XW(XW), .YW(YW)) ia ();
  robm_cmd_sched_if #(.XW(XW), .YW(YW)) ib ();

  assign ia.req0 = req0;
  assign ia.req1 = req1;
  assign ia.cmd0 = cmd0;
  assign ia.cmd1 = cmd1;
  assign ia.y_in = y_in;
  assign ib.req0 = req0;
  assign ib.req1 = req1;
  assign ib.cmd0 = cmd0;
  assign ib.cmd1 = cmd1;
  assign ib.y_in = y_in;

  robm_cmd_sched #(
    .XW(XW), .YW(YW), .HOLD(1), .TMO(4)
  ) ua (
    .clk(clk),
    .rst(rst),
    .bus(ia.slave)
  );

  robm_cmd_sched #(
    .XW(XW), .YW(YW), .HOLD(3), .TMO(6)
  ) ub (
    .clk(clk),
    .rst(rst),
    .bus(ib.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic eg0, input logic eg1,
                         input logic eow, input logic ebz,
                         input logic edn, input logic eto,
                         input logic [XW-1:0] ex,
                         input bit cm,
                         input logic [YW-1:0] eym);
    chk({tag, ".gnt0"}, 32'(sel ? ib.gnt0 : ia.gnt0), 32'(eg0));
    chk({tag, ".gnt1"}, 32'(sel ? ib.gnt1 : ia.gnt1), 32'(eg1));
    chk({tag, ".owner"}, 32'(sel ? ib.owner : ia.owner), 32'(eow));
    chk({tag, ".busy"}, 32'(sel ? ib.busy : ia.busy), 32'(ebz));
    chk({tag, ".done"}, 32'(sel ? ib.done : ia.done), 32'(edn));
    chk({tag, ".timeout"},
        32'(sel ? ib.timeout : ia.timeout), 32'(eto));
    chk({tag, ".x_out"}, 32'(sel ? ib.x_out : ia.x_out), 32'(ex));
    if (cm)
      chk({tag, ".ymask"},
          32'(sel ? ib.ymask : ia.ymask), 32'(eym));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      y_in = 10'($urandom);
      @(posedge clk);
      #1;
      chk_all("idle", 0, 0, m_owner, 0, 0, 0, '0, 1, m_mask);
    end
  endtask

  // One transaction from grant to end. Edge k counts clock edges
  // after the grant edge; DRIVE spans edges 1..H, WAIT follows.
  // y5 during DRIVE completes on the first WAIT edge.
  task automatic run_txn(input bit r0, input bit r1,
                         input logic [XW-1:0] c0,
                         input logic [XW-1:0] c1,
                         input int y4_at, input int y5_at,
                         input bit yrand, input bit keep,
                         input int abort_at);
    bit w;
    logic [XW-1:0] c;
    int fin;
    int e;
    bit isdone;
    logic [YW-1:0] yv;
    logic [YW-1:0] mask;
    w = (r0 && r1) ? !m_owner : r1;
    c = w ? c1 : c0;
    e = (y5_at > H + 1) ? y5_at : H + 1;
    if (y5_at > 0 && e <= H + T) begin
      fin = e;
      isdone = 1'b1;
    end else begin
      fin = H + T;
      isdone = 1'b0;
    end
    @(negedge clk);
    req0 = r0;
    req1 = r1;
    cmd0 = c0;
    cmd1 = c1;
    y_in = yrand ? 10'($urandom) : '0;
    @(posedge clk);
    #1;
    m_owner = w;
    mask = '0;
    chk_all("grant", !w, w, w, 1, 0, 0, c, 1, '0);
    for (int k = 1; k <= fin; k++) begin
      @(negedge clk);
      if (!keep) begin
        req0 = 1'($urandom);
        req1 = 1'($urandom);
        cmd0 = 12'($urandom);
        cmd1 = 12'($urandom);
      end
      yv = yrand ? (10'($urandom) & ~10'h010) : '0;
      if (k == y4_at) yv = yv | 10'h008;
      if (k == y5_at) yv = yv | 10'h010;
      y_in = yv;
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        chk_all("arst", 0, 0, 0, 0, 0, 0, '0, 1, '0);
        @(posedge clk);
        #1;
        chk_all("arsthold", 0, 0, 0, 0, 0, 0, '0, 1, '0);
        rst = 1'b1;
        m_owner = 1'b0;
        m_mask = '0;
        return;
      end
      mask = mask | yv;
      @(posedge clk);
      #1;
      if (k < fin)
        chk_all("run", 0, 0, w, 1, 0, 0,
                (k < H) ? c : (c & ~12'h001), 0, '0);
      else
        chk_all("end", 0, 0, w, 0, isdone, !isdone,
                '0, 1, mask);
    end
    m_mask = mask;
  endtask

  task automatic rand_txns(input int n);
    logic [1:0] r;
    for (int i = 0; i < n; i++) begin
      r = 2'($urandom_range(1, 3));
      run_txn(r[0], r[1], 12'($urandom), 12'($urandom),
              $urandom_range(0, H + 1),
              $urandom_range(0, H + T + 2),
              1'b1, 1'($urandom), 0);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    // reset held with a pending request: nothing may move
    sel = 0;
    H = 1;
    T = 4;
    req0 = 1'b1;
    cmd0 = 12'hFFF;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      y_in = 10'($urandom);
      @(posedge clk);
      #1;
      chk_all("rst", 0, 0, 0, 0, 0, 0, '0, 1, '0);
    end
    rst = 1'b1;
    run_txn(1, 0, 12'hFFF, 12'h000, 0, 2, 0, 0, 0);
    idle(2);

    // single command, y4 in DRIVE, y5 in second WAIT cycle
    run_txn(1, 0, 12'hC01, 12'($urandom), 1, 3, 0, 0, 0);
    idle(1);

    // both held: alternate with one idle cycle between
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 12'($urandom), 12'($urandom),
              0, H + 1, 1, 1, 0);
    idle(1);

    // no y5 at all: timeout
    run_txn(1, 0, 12'($urandom), 12'($urandom), 0, 0, 0, 0, 0);
    idle(1);

    // y5 on the expiry edge: done wins
    run_txn(0, 1, 12'($urandom), 12'($urandom),
            0, H + T, 1, 0, 0);
    idle(1);

    // y5 while still driving
    run_txn(1, 0, 12'($urandom), 12'($urandom), 0, 1, 1, 0, 0);
    idle(1);

    // reset in WAIT after a req1 grant, then tie goes to req1
    run_txn(0, 1, 12'($urandom), 12'($urandom),
            0, 0, 1, 0, H + 2);
    idle(1);
    run_txn(1, 1, 12'($urandom), 12'($urandom), 0, 2, 1, 0, 0);
    idle(1);

    rand_txns(20);

    // second instance with longer hold and timeout
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sel = 1;
    H = 3;
    T = 6;
    m_owner = 1'b0;
    m_mask = '0;
    idle(1);
    run_txn(1, 1, 12'h5A5, 12'hA5B, 2, 0, 0, 0, 0);
    idle(1);
    run_txn(1, 1, 12'h123, 12'h456, 0, H + T, 1, 1, 0);
    run_txn(1, 1, 12'h789, 12'hABC, 0, 2, 1, 1, 0);
    idle(1);
    rand_txns(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/robm_cmd_sched.md
# robm_cmd_sched

Command scheduler for the robm controller FSM. It arbitrates round-robin between two command requesters and drives the granted 12-bit command onto the FSM input vector x. It then watches the FSM output vector y for the return-to-idle indication (y5) and reports completion or timeout back to the requester. It sits between the host/planner command sources and the robm block, and is the only driver of robm's x inputs.

## Interface
- XW, 12, command / x-vector width; bit k drives x(k+1).
- YW, 10, y-vector width; bit k carries y(k+1).
- HOLD, 1, cycles the full command (x1 set) is presented; legal range 1..15.
- TMO, 200, max WAIT cycles before abort; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 command request (level).
- cmd0  in  XW  requester 0 command word; sampled only on grant.
- req1  in  1  requester 1 command request (level).
- cmd1  in  XW  requester 1 command word; sampled only on grant.
- gnt0  out  1  one-cycle pulse: cmd0 accepted.
- gnt1  out  1  one-cycle pulse: cmd1 accepted.
- owner  out  1  requester owning the current or last transaction.
- busy  out  1  high in DRIVE and WAIT.
- x_out  out  XW  vector to robm x1..x12.
- y_in  in  YW  robm y1..y10; sampled on posedge.
- done  out  1  one-cycle pulse: transaction completed (y5 seen).
- timeout  out  1  one-cycle pulse: transaction aborted.
- ymask  out  YW  OR of all y_in samples during the transaction; valid while done or timeout is high, held until the next grant.

## Operation
- States:
  - IDLE: x_out=0.
  - DRIVE: x_out=cmd_reg, including bit0 (x1).
  - WAIT: x_out=cmd_reg with bit0 forced 0, so robm stays in s1 after returning; x4/x7/x2/x3 qualifiers remain held.
- IDLE: if either req is high, grant one requester, latch its cmd into cmd_reg, and go to DRIVE. Set hold_cnt=HOLD-1, clear ymask, clear done_pend.
- Arbitration rules:
  - Single request: grant it.
  - Both requests: grant the requester that is not the current owner (round-robin).
  - After reset, owner=0, so req1 wins the first tie.
- DRIVE: OR y_in into ymask each cycle. If y_in[4] is seen, set done_pend. When hold_cnt reaches 0, go to WAIT with wait_cnt=0; otherwise decrement hold_cnt.
- WAIT: OR y_in into ymask each cycle.
  - If y_in[4]=1 or done_pend=1: pulse done, go to IDLE.
  - Else if wait_cnt==TMO-1: pulse timeout, go to IDLE.
  - Else increment wait_cnt (8-bit, no wrap possible within the legal TMO range).
- Simultaneous y5 and timeout expiry: done wins; timeout is not asserted.
- Requests are ignored outside IDLE. A req dropped after grant has no effect. Each transaction runs to done or timeout.
- At least one IDLE cycle separates transactions, so a held req is re-granted no earlier than 1 cycle after done/timeout.

## Timing
- All outputs are registered.
- Reset values: gnt0=gnt1=0, owner=0, busy=0, x_out=0, done=0, timeout=0, ymask=0, state IDLE, all counters 0.
- Reset is asynchronous and takes effect mid-transaction: x_out drops to 0 immediately, and no done/timeout is issued for the aborted transaction.
- Grant timing: req sampled high at IDLE edge N. Edge N asserts gnt (1 cycle) and busy, updates owner, and sets x_out=cmd.
- DRIVE occupies exactly HOLD cycles: x1 is high for HOLD cycles starting at edge N.
- Completion: y5 sampled at WAIT edge M makes done high for cycle M to M+1, with busy=0 and x_out=0 from M.
- Minimum transaction (HOLD=1, y5 in first WAIT cycle): gnt to done is 2 cycles.
- Maximum WAIT length is TMO cycles; timeout asserts TMO cycles after WAIT entry.
- Worst case, grant to done/timeout is HOLD+TMO cycles.

## Test plan
- Reset: rst=0 with req0=1 and cmd0=12'hFFF. All outputs stay 0 and no gnt occurs. After release, gnt0 pulses 1 cycle later.
- Single command: req0=1, cmd0=12'hC01 (x1, x11, x12 set), HOLD=1. Expected: gnt0, x_out=12'hC01 for 1 cycle, then 12'hC00. y_in=10'h010 in the 2nd WAIT cycle gives a done pulse, ymask=10'h018 (y4 seen earlier plus y5), busy=0.
- Round-robin: req0 and req1 held continuously with immediate y5 each time. Grants alternate gnt1, gnt0, gnt1, ... with exactly one IDLE cycle between transactions.
- Timeout: TMO=4 with y_in held at 0. timeout pulses 4 cycles after WAIT entry, done stays 0, x_out returns to 0.
- Race: y5 arrives on the same edge as wait_cnt==TMO-1. Expected: done=1, timeout=0.
- Mid-op reset: assert rst=0 during WAIT. x_out=0 immediately and no done/timeout pulse. After release, a new req1 is granted normally with owner=1.
